bridge_2x1: RTL and testbench
=============================

BRIDGE_2X1 -- requirements
Module: bridge_2x1

Interface
REQ-001 Parameter RR_EN, default 1, meaning: 1 = round-robin arbitration, 0 = fixed priority to m1.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 m0_en / m0_wen / m0_addr / m0_wdata  input  1 / 4 / XLEN / XLEN  master 0 (instruction fetch) request; wen byte enables, all-zero = read.
REQ-005 m0_rdata  output  XLEN  master 0 read data.
REQ-006 m0_rvalid  output  1  master 0 read data valid.
REQ-007 m0_stall  output  1  master 0 request not accepted this cycle.
REQ-008 m1_en, m1_wen, m1_addr, m1_wdata, m1_rdata, m1_rvalid, m1_stall  same directions, widths and meanings as m0_*, for master 1 (CPU data).
REQ-009 s_en / s_wen / s_addr / s_wdata  output  1 / 4 / XLEN / XLEN  request to a single-port sram slave with 1-cycle read latency.
REQ-010 s_rdata  input  XLEN  slave read data, valid the cycle after the read is issued.
REQ-011 conflict_cnt  output  32  saturating count of cycles in which m0_en and m1_en are both high.

Function
REQ-012 A single requester is always granted in the same cycle.
REQ-013 With both requesting and RR_EN=1, the master not granted on the most recent grant wins; with RR_EN=0, m1 wins.
REQ-014 The last-grant pointer updates on every cycle with a grant and holds otherwise.
REQ-015 mX_stall = mX_en AND NOT grantX, combinational; a stalled master holds en/wen/addr/wdata stable until stall is low.
REQ-016 s_en/s_wen/s_addr/s_wdata are the winner's signals, combinational; s_en=0 and s_wen=0 with no requester; s_addr and s_wdata are don't-care when s_en=0.
REQ-017 A granted write completes in the grant cycle with no rvalid pulse.
REQ-018 A read granted in cycle N gives mX_rvalid=1 in cycle N+1 only, with mX_rdata equal to s_rdata in N+1.
REQ-019 Response owner and valid are registered; a new grant in N+1 does not disturb the N+1 response.
REQ-020 mX_rdata holds its last returned value until that master's next response; it does not follow the other master's data.
REQ-021 Back-to-back reads by one master give one rvalid per cycle.
REQ-022 A read response for one master and a new grant for the other are allowed in the same cycle.
REQ-023 conflict_cnt increments by 1 per cycle with both en high and saturates at 32'hFFFF_FFFF.

Reset
REQ-024 In any cycle with reset high, the next edge clears m0_rvalid, m1_rvalid, the response-valid register, m0_rdata/m1_rdata hold registers and conflict_cnt to 0.
REQ-025 The same edge sets the last-grant pointer to m0, so that m1 wins the first conflict.
REQ-026 A read in flight when reset is asserted is discarded: no rvalid in the following cycle.

Structure
REQ-027 XLEN comes from cpu.vh; grant encodings (GNT_M0=0, GNT_M1=1) are added to cpu.vh.
REQ-028 Grant and last-grant pointer logic is one sub-module, arb_rr2, with request inputs, grant outputs and an RR_EN parameter.
REQ-029 bridge_2x1 holds the response pipeline, the rdata hold registers and the counter.

Verification
REQ-030 Idle then m0 read of 0x100, sram word 0xDEADBEEF -> m0_stall=0, next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF, m1_rvalid=0.
REQ-031 After reset, m0 and m1 both read for 4 cycles -> grants m1,m0,m1,m0; each stalled master holds its request; conflict_cnt=4.
REQ-032 With RR_EN=0, both request for 3 cycles -> m1 granted all 3 cycles, m0_stall=1 throughout.
REQ-033 m1 writes 0x12345678 with wen=4'b0011 to 0x40, then m1 reads 0x40 (prior word 0) -> rdata=0x00005678, no rvalid on the write cycle.
REQ-034 m0 read granted, reset high the next cycle -> m0_rvalid=0 and m0_rdata=0 after the edge.
REQ-035 Force conflict_cnt to 0xFFFFFFFE, then both request for 3 cycles -> count reads 0xFFFFFFFF and stays there.

Source files
------------

// File: rtl/bridge_2x1_pkg.sv
// Shared definitions for the two-master to single-sram bridge.
package bridge_2x1_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic {
    GNT_M0 = 1'b0,
    GNT_M1 = 1'b1
  } gnt_e;

endpackage

// File: rtl/bridge_2x1_arb_rr2.sv
// Two-requester arbiter: single requests granted immediately, conflicts
// resolved by round-robin on the last grant or fixed priority to req1.
module arb_rr2
  import bridge_2x1_pkg::*;
#(
  parameter int unsigned RR_EN = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  gnt_e last_gnt;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      // Round-robin hands the conflict to whoever did not win last time.
      if ((RR_EN != 0) && (last_gnt == GNT_M1)) begin
        gnt0 = 1'b1;
      end else begin
        gnt1 = 1'b1;
      end
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt <= GNT_M0;
    end else if (gnt1) begin
      last_gnt <= GNT_M1;
    end else if (gnt0) begin
      last_gnt <= GNT_M0;
    end
  end

endmodule

// File: rtl/bridge_2x1.sv
// Bridges instruction-fetch (m0) and data (m1) masters onto one sram port
// with a registered one-cycle read response and per-master rdata hold.
module bridge_2x1
  import bridge_2x1_pkg::*;
#(
  parameter int unsigned RR_EN = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            m0_en,
  input  logic [3:0]      m0_wen,
  input  logic [XLEN-1:0] m0_addr,
  input  logic [XLEN-1:0] m0_wdata,
  output logic [XLEN-1:0] m0_rdata,
  output logic            m0_rvalid,
  output logic            m0_stall,
  input  logic            m1_en,
  input  logic [3:0]      m1_wen,
  input  logic [XLEN-1:0] m1_addr,
  input  logic [XLEN-1:0] m1_wdata,
  output logic [XLEN-1:0] m1_rdata,
  output logic            m1_rvalid,
  output logic            m1_stall,
  output logic            s_en,
  output logic [3:0]      s_wen,
  output logic [XLEN-1:0] s_addr,
  output logic [XLEN-1:0] s_wdata,
  input  logic [XLEN-1:0] s_rdata,
  output logic [31:0]     conflict_cnt
);

  logic            gnt0;
  logic            gnt1;
  logic            resp_valid;
  gnt_e            resp_owner;
  logic [XLEN-1:0] m0_hold;
  logic [XLEN-1:0] m1_hold;

  arb_rr2 #(.RR_EN(RR_EN)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req0  (m0_en),
    .req1  (m1_en),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  always_comb begin
    s_en    = 1'b0;
    s_wen   = '0;
    s_addr  = '0;
    s_wdata = '0;
    if (gnt1) begin
      s_en    = 1'b1;
      s_wen   = m1_wen;
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
    end else if (gnt0) begin
      s_en    = 1'b1;
      s_wen   = m0_wen;
      s_addr  = m0_addr;
      s_wdata = m0_wdata;
    end
  end

  assign m0_stall  = m0_en & ~gnt0;
  assign m1_stall  = m1_en & ~gnt1;

  assign m0_rvalid = resp_valid && (resp_owner == GNT_M0);
  assign m1_rvalid = resp_valid && (resp_owner == GNT_M1);

  // Live sram data during a response, otherwise the last captured word.
  assign m0_rdata  = m0_rvalid ? s_rdata : m0_hold;
  assign m1_rdata  = m1_rvalid ? s_rdata : m1_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid   <= 1'b0;
      resp_owner   <= GNT_M0;
      m0_hold      <= '0;
      m1_hold      <= '0;
      conflict_cnt <= '0;
    end else begin
      resp_valid <= s_en && (s_wen == '0);
      resp_owner <= gnt1 ? GNT_M1 : GNT_M0;
      if (m0_rvalid) begin
        m0_hold <= s_rdata;
      end
      if (m1_rvalid) begin
        m1_hold <= s_rdata;
      end
      if (m0_en && m1_en && (conflict_cnt != '1)) begin
        conflict_cnt <= conflict_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_bridge_2x1.sv
// Randomized and directed checks of bridge_2x1 against a transaction-level
// model with its own memory image and a behavioural sram slave.
module tb_bridge_2x1;
  import bridge_2x1_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            m0_en, m1_en;
  logic [3:0]      m0_wen, m1_wen;
  logic [XLEN-1:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic            m0_rvalid, m0_stall, m1_rvalid, m1_stall;
  logic            s_en;
  logic [3:0]      s_wen;
  logic [XLEN-1:0] s_addr, s_wdata, s_rdata;
  logic [31:0]     conflict_cnt;

  logic            fp_m0_rvalid, fp_m0_stall, fp_m1_rvalid, fp_m1_stall, fp_s_en;
  logic [XLEN-1:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
  logic [3:0]      fp_s_wen;
  logic [31:0]     fp_conflict_cnt;

  bridge_2x1 #(.RR_EN(1)) dut (
    .clk(clk), .reset(reset),
    .m0_en(m0_en), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_stall(m0_stall),
    .m1_en(m1_en), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_stall(m1_stall),
    .s_en(s_en), .s_wen(s_wen), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .conflict_cnt(conflict_cnt)
  );

  bridge_2x1 #(.RR_EN(0)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_en(m0_en), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(fp_m0_rdata), .m0_rvalid(fp_m0_rvalid), .m0_stall(fp_m0_stall),
    .m1_en(m1_en), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(fp_m1_rdata), .m1_rvalid(fp_m1_rvalid), .m1_stall(fp_m1_stall),
    .s_en(fp_s_en), .s_wen(fp_s_wen), .s_addr(fp_s_addr), .s_wdata(fp_s_wdata),
    .s_rdata(s_rdata), .conflict_cnt(fp_conflict_cnt)
  );

  // Behavioural single-port sram with one-cycle read latency.
  logic        clr, pre_en;
  logic [9:0]  pre_idx;
  logic [31:0] pre_data;
  logic [31:0] sram [0:1023];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) sram[i] <= '0;
    end else if (pre_en) begin
      sram[pre_idx] <= pre_data;
    end else if (s_en) begin
      if (s_wen == 4'h0) s_rdata <= sram[s_addr[11:2]];
      else for (int b = 0; b < 4; b++)
        if (s_wen[b]) sram[s_addr[11:2]][8*b +: 8] <= s_wdata[8*b +: 8];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] ref_mem [0:1023];
  int          last_g = 0;
  bit          pend_v = 0;
  int          pend_o = 0;
  logic [31:0] pend_d = '0;
  logic [31:0] hold0 = '0, hold1 = '0;
  logic [31:0] exp_cnt = '0, fp_cnt = '0;
  bit          st0 = 0, st1 = 0;

  // Current master stimulus
  logic        c0_en = 0, c1_en = 0;
  logic [3:0]  c0_wen = '0, c1_wen = '0;
  logic [31:0] c0_addr = '0, c0_wdata = '0, c1_addr = '0, c1_wdata = '0;

  task automatic set_m0(input logic en, input logic [3:0] wen, input logic [31:0] a, input logic [31:0] d);
    c0_en = en; c0_wen = wen; c0_addr = a; c0_wdata = d;
  endtask

  task automatic set_m1(input logic en, input logic [3:0] wen, input logic [31:0] a, input logic [31:0] d);
    c1_en = en; c1_wen = wen; c1_addr = a; c1_wdata = d;
  endtask

  task automatic run_cycle(input logic rst);
    int g, gf, idx;
    logic [3:0]  w;
    logic [31:0] a, d;
    bit r0, r1;
    @(negedge clk);
    reset = rst;
    m0_en = c0_en; m0_wen = c0_wen; m0_addr = c0_addr; m0_wdata = c0_wdata;
    m1_en = c1_en; m1_wen = c1_wen; m1_addr = c1_addr; m1_wdata = c1_wdata;
    #2;
    r0 = pend_v && (pend_o == 0);
    r1 = pend_v && (pend_o == 1);
    check_eq("m0_rvalid", 32'(m0_rvalid), 32'(r0));
    check_eq("m1_rvalid", 32'(m1_rvalid), 32'(r1));
    check_eq("m0_rdata", m0_rdata, r0 ? pend_d : hold0);
    check_eq("m1_rdata", m1_rdata, r1 ? pend_d : hold1);
    check_eq("conflict_cnt", conflict_cnt, exp_cnt);
    check_eq("fp_conflict_cnt", fp_conflict_cnt, fp_cnt);
    if (rst) begin
      pend_v = 0; hold0 = '0; hold1 = '0;
      exp_cnt = '0; fp_cnt = '0; last_g = 0; st0 = 0; st1 = 0;
    end else begin
      if (c0_en && c1_en) g = (last_g == 0) ? 1 : 0;
      else if (c1_en)     g = 1;
      else if (c0_en)     g = 0;
      else                g = -1;
      gf = c1_en ? 1 : (c0_en ? 0 : -1);
      st0 = c0_en && (g != 0);
      st1 = c1_en && (g != 1);
      check_eq("m0_stall", 32'(m0_stall), 32'(st0));
      check_eq("m1_stall", 32'(m1_stall), 32'(st1));
      check_eq("s_en", 32'(s_en), 32'(g >= 0));
      check_eq("fp_m0_stall", 32'(fp_m0_stall), 32'(c0_en && (gf != 0)));
      check_eq("fp_m1_stall", 32'(fp_m1_stall), 32'(c1_en && (gf != 1)));
      if (r0) hold0 = pend_d;
      if (r1) hold1 = pend_d;
      pend_v = 0;
      if (g >= 0) begin
        w = (g == 1) ? c1_wen : c0_wen;
        a = (g == 1) ? c1_addr : c0_addr;
        d = (g == 1) ? c1_wdata : c0_wdata;
        check_eq("s_wen", 32'(s_wen), 32'(w));
        check_eq("s_addr", s_addr, a);
        if (w != 4'h0) check_eq("s_wdata", s_wdata, d);
        idx = int'(a[11:2]);
        if (w == 4'h0) begin
          pend_v = 1; pend_o = g; pend_d = ref_mem[idx];
        end else begin
          for (int b = 0; b < 4; b++)
            if (w[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
        end
        last_g = g;
      end else begin
        check_eq("s_wen_idle", 32'(s_wen), 32'h0);
      end
      if (c0_en && c1_en) begin
        if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
        if (fp_cnt != 32'hFFFF_FFFF) fp_cnt = fp_cnt + 1;
      end
    end
  endtask

  task automatic idle();
    set_m0(0, 4'h0, '0, '0);
    set_m1(0, 4'h0, '0, '0);
  endtask

  task automatic rand_stim();
    if (!st0) set_m0($urandom_range(0, 3) != 0,
                     ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                     32'($urandom_range(0, 31)) << 2, $urandom);
    if (!st1) set_m1($urandom_range(0, 3) != 0,
                     ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                     32'($urandom_range(0, 31)) << 2, $urandom);
  endtask

  initial begin
    logic [3:0] pat0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    reset = 1'b1; clr = 1'b1; pre_en = 1'b0; pre_idx = '0; pre_data = '0;
    m0_en = 0; m0_wen = '0; m0_addr = '0; m0_wdata = '0;
    m1_en = 0; m1_wen = '0; m1_addr = '0; m1_wdata = '0;
    repeat (2) @(posedge clk);
    run_cycle(1);
    clr = 1'b0;
    run_cycle(1);

    // Reset state, then a single m0 read of a preloaded word.
    pre_en = 1'b1; pre_idx = 10'd64; pre_data = 32'hDEAD_BEEF; ref_mem[64] = 32'hDEAD_BEEF;
    run_cycle(0);
    pre_en = 1'b0;
    check_eq("reset_cnt", conflict_cnt, 32'h0);
    check_eq("reset_m0_rdata", m0_rdata, 32'h0);
    set_m0(1, 4'h0, 32'h100, '0);
    run_cycle(0);
    check_eq("single_m0_stall", 32'(m0_stall), 32'h0);
    idle();
    run_cycle(0);
    check_eq("single_m0_rvalid", 32'(m0_rvalid), 32'h1);
    check_eq("single_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    check_eq("single_m1_rvalid", 32'(m1_rvalid), 32'h0);

    // Partial write then read back by m1.
    set_m1(1, 4'b0011, 32'h40, 32'h1234_5678);
    run_cycle(0);
    set_m1(1, 4'h0, 32'h40, '0);
    run_cycle(0);
    check_eq("wr_no_rvalid", 32'(m1_rvalid), 32'h0);
    idle();
    run_cycle(0);
    check_eq("wr_readback", m1_rdata, 32'h0000_5678);

    // Both masters read for 4 cycles straight after reset.
    run_cycle(1);
    pat0 = 4'b0101;
    set_m0(1, 4'h0, 32'h10, '0);
    set_m1(1, 4'h0, 32'h20, '0);
    for (int i = 0; i < 4; i++) begin
      run_cycle(0);
      check_eq("rr_m0_stall", 32'(m0_stall), 32'(pat0[i]));
      check_eq("rr_m1_stall", 32'(m1_stall), 32'(!pat0[i]));
      check_eq("fp_m0_always_stall", 32'(fp_m0_stall), 32'h1);
    end
    idle();
    run_cycle(0);
    check_eq("rr_conflict_4", conflict_cnt, 32'd4);

    // Read in flight when reset arrives.
    set_m0(1, 4'h0, 32'h100, '0);
    run_cycle(0);
    idle();
    run_cycle(1);
    run_cycle(0);
    check_eq("rst_inflight_rvalid", 32'(m0_rvalid), 32'h0);
    check_eq("rst_inflight_rdata", m0_rdata, 32'h0);

    // Counter saturation.
    force dut.conflict_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.conflict_cnt;
    exp_cnt = 32'hFFFF_FFFE;
    set_m0(1, 4'h0, 32'h10, '0);
    set_m1(1, 4'h0, 32'h20, '0);
    repeat (3) run_cycle(0);
    idle();
    run_cycle(0);
    check_eq("sat_cnt", conflict_cnt, 32'hFFFF_FFFF);
    run_cycle(0);
    check_eq("sat_cnt_hold", conflict_cnt, 32'hFFFF_FFFF);

    // Randomized traffic with occasional reset.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        idle();
        run_cycle(1);
      end else begin
        rand_stim();
        run_cycle(0);
      end
    end
    idle();
    run_cycle(0);
    run_cycle(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
